// File: rtl/pipe_square_pkg.sv
// Shared types and helpers for the pipelined squarer.
// stage_t is sized from SQ_W, so pipe_square must be built with W == SQ_W.
package pipe_square_pkg;

  localparam int SQ_W  = 4;
  localparam int SQ_DW = 2 * SQ_W;

  // One pipeline slot: the root (zero-extended) and the partial sum so far.
  typedef struct packed {
    logic             valid;
    logic [SQ_DW-1:0] x;
    logic [SQ_DW-1:0] acc;
  } stage_t;

  // Reference square, used by the optional output self-check and by benches.
  function automatic logic [SQ_DW-1:0] sq_ref(input logic [SQ_W-1:0] x);
    logic [SQ_DW-1:0] xe;
    xe = SQ_DW'(x);
    return xe * xe;
  endfunction

endpackage

// File: rtl/pipe_square_if.sv
// Elastic input/output handshake bundle for pipe_square.
// master = producer/consumer side, slave = the squarer itself.
interface pipe_square_if #(
  parameter int W = pipe_square_pkg::SQ_W
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_root;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_sq;
  logic           err;

  modport master (
    output in_valid, in_root, out_ready,
    input  in_ready, out_valid, out_sq, err
  );

  modport slave (
    input  in_valid, in_root, out_ready,
    output in_ready, out_valid, out_sq, err
  );
endinterface

// File: rtl/pipe_square_stage.sv
// One shift-add step: adds (x << I) to the running sum when root bit I is set,
// and moves the slot forward only when the whole pipe advances.
module square_stage
  import pipe_square_pkg::*;
#(
  parameter int I = 0,
  parameter int W = SQ_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  input  stage_t stage_in,
  output stage_t stage_out
);

  logic [W-1:0]     root;
  logic [SQ_DW-1:0] addend;

  // Partial product for this bit position.
  always_comb begin
    root   = stage_in.x[W-1:0];
    addend = root[I] ? (SQ_DW'(root) << I) : '0;
  end

  // Register the slot; bubbles shift through like data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_out <= '0;
    end else if (adv) begin
      stage_out.valid <= stage_in.valid;
      stage_out.x     <= stage_in.x;
      stage_out.acc   <= stage_in.acc + addend;
    end
  end

endmodule

// File: rtl/pipe_square.sv
// Pipelined squarer: W-bit root in, exact 2W-bit square out, W cycles latency.
// The whole pipe advances together when the output slot is empty or being taken.
// Optional macro SQUARE_SELFCHECK_EN adds a shadow root pipeline and a sticky
// err flag raised when an emitted square disagrees with x*x.
module pipe_square
  import pipe_square_pkg::*;
#(
  parameter int W = SQ_W
) (
  input logic         clk,
  input logic         rst,
  pipe_square_if.slave bus
);

  stage_t in_stage_reg;
  stage_t stage_q [W];
  logic   adv;

  // Global stall: hold everything only while a result is waiting unaccepted.
  always_comb begin
    adv          = !stage_q[W-1].valid || bus.out_ready;
    bus.in_ready = adv;
  end

  // Entry slot: a raw root with a zero sum, or a bubble when nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_stage_reg <= '0;
    end else if (adv) begin
      in_stage_reg.valid <= bus.in_valid;
      in_stage_reg.x     <= SQ_DW'(bus.in_root);
      in_stage_reg.acc   <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        square_stage #(.I(gi), .W(W)) u_stage (
          .clk      (clk),
          .rst      (rst),
          .adv      (adv),
          .stage_in (in_stage_reg),
          .stage_out(stage_q[gi])
        );
      end else begin : g_rest
        square_stage #(.I(gi), .W(W)) u_stage (
          .clk      (clk),
          .rst      (rst),
          .adv      (adv),
          .stage_in (stage_q[gi-1]),
          .stage_out(stage_q[gi])
        );
      end
    end
  endgenerate

  assign bus.out_valid = stage_q[W-1].valid;
  assign bus.out_sq    = stage_q[W-1].acc;

`ifdef SQUARE_SELFCHECK_EN
  logic [W-1:0] shadow_reg [W+1];
  logic         err_reg;
  logic         chk_fire;

  // Independent copy of each root travelling in lockstep with its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= W; i++) shadow_reg[i] <= '0;
    end else if (adv) begin
      shadow_reg[0] <= bus.in_root;
      for (int i = 0; i < W; i++) shadow_reg[i+1] <= shadow_reg[i];
    end
  end

  // Shadow slot W lines up with the output slot (entry register + W stages).
  assign chk_fire = bus.out_valid && bus.out_ready &&
                    (bus.out_sq != sq_ref(shadow_reg[W]));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (chk_fire) begin
      err_reg <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of the offending result.
  always_ff @(posedge clk) begin
    if (!rst && chk_fire) begin
      $error("pipe_square self-check: out_sq=%0d root=%0d", bus.out_sq, shadow_reg[W]);
    end
  end
`endif

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_square.sv
module tb_pipe_square;
  import pipe_square_pkg::*;

  localparam int W = SQ_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_square_if #(.W(W)) bus ();

  pipe_square #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int a);
    int b;
    b = 0;
    while ((b + 1) * (b + 1) <= a) b++;
    return b;
  endfunction

  // Model: every accepted root is an item counting how many global advances it
  // has seen; it sits at the output after exactly W advances.
  typedef struct {
    logic [2*W-1:0] sq;
    int             advs;
  } item_t;

  item_t          mdl_q[$];
  logic [2*W-1:0] out_log[$];
  int             rt_a_q[$];
  int             rt_a_cur = 0;
  int             rt_checked = 0;
  bit             rt_mode = 0;
  bit             armed = 0;
  bit             acc_seen = 0;

  // Compare process: judge outputs and the coming edge's handshakes at negedge.
  always @(negedge clk) begin
    if (armed) begin
      bit    m_valid;
      bit    m_adv;
      item_t it;
      m_valid = (mdl_q.size() > 0) && (mdl_q[0].advs == W);
      m_adv   = !m_valid || bus.out_ready;
      check("out_valid", bus.out_valid, m_valid);
      if (m_valid) check("out_sq", bus.out_sq, mdl_q[0].sq);
      check("in_ready", bus.in_ready, m_adv);
      check("err", bus.err, 0);
      acc_seen = bus.in_valid && m_adv && !rst;
      if (rst) begin
        mdl_q.delete();
        rt_a_q.delete();
      end else begin
        if (m_valid && bus.out_ready) begin
          out_log.push_back(bus.out_sq);
          if (rt_mode && rt_a_q.size() > 0) begin
            int a;
            int b;
            a = rt_a_q.pop_front();
            b = isqrt(a);
            check("rt_le", (int'(bus.out_sq) <= a), 1);
            check("rt_next_gt", (int'(bus.out_sq) + 2 * b + 1 > a), 1);
            rt_checked++;
          end
          void'(mdl_q.pop_front());
        end
        if (m_adv) begin
          foreach (mdl_q[i]) mdl_q[i].advs++;
          if (bus.in_valid) begin
            it.sq   = (2*W)'(bus.in_root) * (2*W)'(bus.in_root);
            it.advs = 0;
            mdl_q.push_back(it);
            if (rt_mode) rt_a_q.push_back(rt_a_cur);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one root, then measure cycles from its accept edge to out_valid.
  task automatic single(input logic [W-1:0] root, input int exp_sq);
    int lat;
    logic [63:0] sq_at;
    bit found;
    lat = -1;
    sq_at = '0;
    found = 0;
    bus.in_valid = 1'b1;
    bus.in_root  = root;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!found && bus.out_valid) begin
        lat = k;
        sq_at = bus.out_sq;
        found = 1;
      end
    end
    check("single_latency", lat, W);
    check("single_sq", sq_at, exp_sq);
    step();
  endtask

  initial begin
    int n;
    int cyc;
    int a;
    bit seen;

    // Reset with a pending root that must never be taken.
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_root   = 4'd7;
    bus.out_ready = 1'b1;
    step();
    armed = 1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sq", bus.out_sq, 0);
    check("rst_in_ready", bus.in_ready, 1);
    repeat (8) step();
    check("rst_no_output", out_log.size(), 0);

    // Single items with exact latency.
    single(4'd15, 225);
    single(4'd0, 0);

    // Streaming all roots back to back.
    out_log.delete();
    for (int r = 0; r < 16; r++) begin
      bus.in_valid = 1'b1;
      bus.in_root  = 4'(r);
      step();
      check("stream_accept", acc_seen, 1);
    end
    bus.in_valid = 1'b0;
    repeat (8) step();
    check("stream_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) check("stream_val", out_log[i], i * i);

    // Backpressure on the first result.
    out_log.delete();
    foreach (out_log[i]) out_log.delete(i);
    bus.in_valid = 1'b1;
    bus.in_root = 4'd3; step();
    bus.in_root = 4'd5; step();
    bus.in_root = 4'd9; step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("bp_arrived", seen, 1);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_hold_sq", bus.out_sq, 9);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    repeat (6) step();
    check("bp_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("bp_first", out_log[0], 9);
      check("bp_second", out_log[1], 25);
      check("bp_third", out_log[2], 81);
    end

    // Reset while two roots are in flight.
    out_log.delete();
    bus.in_valid = 1'b1;
    bus.in_root = 4'd12; step();
    bus.in_root = 4'd13; step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    check("flush_no_output", out_log.size(), 0);
    @(negedge clk);
    check("flush_empty", bus.out_valid, 0);

    // Round trip: roots are integer square roots of random 8-bit values.
    out_log.delete();
    rt_mode = 1;
    n = 0;
    cyc = 0;
    bus.in_valid = 1'b0;
    step();
    while (n < 200 && cyc < 5000) begin
      if (bus.in_valid && acc_seen) begin
        n++;
        bus.in_valid = 1'b0;
      end
      if (!bus.in_valid && n < 200 && $urandom_range(3) != 0) begin
        a = int'($urandom_range(255));
        rt_a_cur = a;
        bus.in_root = 4'(isqrt(a));
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) step();
    check("rt_accepted", n, 200);
    check("rt_checked", rt_checked, 200);
    check("rt_drained", rt_a_q.size(), 0);
    check("rt_err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
